bcd_converter_seq: RTL

Parametrised, multi-cycle binary-to-BCD converter that performs shift-and-add-3 one bit per clock behind a valid/ready handshake. It supersedes the combinational 16-bit converter on the seven-segment display path. It adds generic width, an optional two's-complement sign mode, full-range digit count and a leading-zero blanking mask. It sits between the register-file display tap and the seven-segment decoders.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_add3_digit.sv | 20 ++
 rtl/bcd_converter_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_e        : converter FSM states
//   ADD3_THRESH/VAL: shift-and-add-3 digit correction constants
//   min_bcd_digits : decimal digits needed to hold any BIN_WIDTH-bit magnitude
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam int unsigned ADD3_THRESH = 5;
  localparam int unsigned ADD3_VAL    = 3;

  // ceil(width * log10(2)), with log10(2) approximated as 0.30103
  function automatic int unsigned min_bcd_digits(input int unsigned width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Combinational double-dabble digit correction: digits >= 5 get +3 so the
// following left shift carries correctly into the next decimal digit.
//   digit_i : 4-bit BCD digit before correction
//   digit_o : corrected digit
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    if (digit_i >= 4'(ADD3_THRESH)) begin
      digit_o = digit_i + 4'(ADD3_VAL);
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/bcd_converter_seq.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3, one bit per clock)
// behind valid/ready handshakes on input and output.
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   in_valid     : bin_in / signed_mode valid
//   in_ready     : operand can be accepted (1 in IDLE, out_ready in DONE)
//   bin_in       : operand, BIN_WIDTH bits
//   signed_mode  : 1 = bin_in is two's complement
//   out_valid    : result fields valid and held
//   out_ready    : consumer accepts the result
//   bcd_out      : packed BCD digits, units in [3:0]
//   negative     : result sign (signed_mode only)
//   digit_en     : per-digit display enable, leading zeros blanked
module bcd_converter_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 16,
  parameter int unsigned DIGITS    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  input  logic                  signed_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  negative,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int unsigned SR_W  = BCD_W + BIN_WIDTH;

  if (BIN_WIDTH < 2) begin : g_width_check
    $error("bcd_converter_seq: BIN_WIDTH must be at least 2");
  end

  if (DIGITS < min_bcd_digits(BIN_WIDTH)) begin : g_digits_check
    $error("bcd_converter_seq: DIGITS too small for BIN_WIDTH");
  end

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SR_W-1:0]      sr_q, sr_d;
  logic                 sign_q, sign_d;
  logic [BCD_W-1:0]     bcd_out_q, bcd_out_d;
  logic                 negative_q, negative_d;
  logic [DIGITS-1:0]    digit_en_q, digit_en_d;

  logic                 in_ready_c;
  logic                 accept;
  logic                 is_neg;
  logic [BIN_WIDTH-1:0] mag;
  logic [BCD_W-1:0]     bcd_corr;
  logic [SR_W-1:0]      sr_step;
  logic [BCD_W-1:0]     step_bcd;
  logic [DIGITS-1:0]    step_en;

  // Add-3 correction on every digit in parallel, ahead of the shift
  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_i (sr_q[BIN_WIDTH + 4*i +: 4]),
      .digit_o (bcd_corr[4*i +: 4])
    );
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM outputs ----------------
  always_comb begin
    in_ready_c = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      IDLE:    in_ready_c = 1'b1;
      DONE: begin
        in_ready_c = out_ready;
        out_valid  = 1'b1;
      end
      default: in_ready_c = 1'b0;
    endcase
  end

  assign in_ready = in_ready_c;
  assign accept   = in_valid & in_ready_c;

  // Negation is taken modulo 2^BIN_WIDTH, so the most negative operand
  // yields its true unsigned magnitude.
  assign is_neg = signed_mode & bin_in[BIN_WIDTH-1];
  assign mag    = is_neg ? (~bin_in + BIN_WIDTH'(1)) : bin_in;

  assign sr_step  = {bcd_corr, sr_q[BIN_WIDTH-1:0]} << 1;
  assign step_bcd = sr_step[SR_W-1:BIN_WIDTH];

  // Blanking: scan from the most significant digit down, enabling every
  // digit at or below the highest nonzero one; units always shown.
  always_comb begin
    logic        any_nz;
    int unsigned idx;
    any_nz  = 1'b0;
    idx     = 0;
    step_en = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      idx          = DIGITS - 1 - k;
      any_nz       = any_nz | (step_bcd[4*idx +: 4] != 4'd0);
      step_en[idx] = any_nz;
    end
    step_en[0] = 1'b1;
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    bcd_out_d  = bcd_out_q;
    negative_d = negative_q;
    digit_en_d = digit_en_q;
    if (accept) begin
      sr_d   = {{BCD_W{1'b0}}, mag};
      cnt_d  = CNT_W'(BIN_WIDTH);
      sign_d = is_neg;
    end else if (state_q == SHIFT) begin
      sr_d  = sr_step;
      cnt_d = cnt_q - CNT_W'(1);
      // Last iteration: publish the result in the same edge that enters DONE
      if (cnt_q == CNT_W'(1)) begin
        bcd_out_d  = step_bcd;
        negative_d = sign_q;
        digit_en_d = step_en;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      sr_q       <= '0;
      sign_q     <= 1'b0;
      bcd_out_q  <= '0;
      negative_q <= 1'b0;
      digit_en_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      sign_q     <= sign_d;
      bcd_out_q  <= bcd_out_d;
      negative_q <= negative_d;
      digit_en_q <= digit_en_d;
    end
  end

  assign bcd_out  = bcd_out_q;
  assign negative = negative_q;
  assign digit_en = digit_en_q;

endmodule
